// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC registers the ALU output, RESP holds it until consumed.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic        resp0_zero,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic        resp1_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        prio_q, owner_q;
    logic [31:0] a_q, b_q, result_q;
    logic [3:0]  op_q;
    logic        zero_q;

    logic        gnt_any, gnt, accept, resp_hs;
    logic [31:0] sel_a, sel_b;
    logic [3:0]  sel_op;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        gnt_any = req0_valid || req1_valid;
        // Round-robin only matters under contention; a lone requester always wins.
        gnt     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        accept  = !rst && (state_q == IDLE) && gnt_any;
        resp_hs = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);
        sel_a   = gnt ? req1_a  : req0_a;
        sel_b   = gnt ? req1_b  : req0_b;
        sel_op  = gnt ? req1_op : req0_op;

        case (state_q)
            IDLE:    if (accept)  state_d = EXEC;
            EXEC:                 state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                op_q    <= sel_op;
                owner_q <= gnt;
                prio_q  <= ~gnt;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    // Outputs are forced quiet while rst is high, before the first reset edge has landed.
    assign req0_ready   = accept && !gnt;
    assign req1_ready   = accept &&  gnt;
    assign resp0_valid  = !rst && (state_q == RESP) && !owner_q;
    assign resp1_valid  = !rst && (state_q == RESP) &&  owner_q;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;
    assign alu_a        = rst ? '0 : a_q;
    assign alu_b        = rst ? '0 : b_q;
    assign alu_ctrl     = rst ? '0 : op_q;
    assign busy         = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        resp0_valid, resp0_ready, resp0_zero;
    logic        resp1_valid, resp1_ready, resp1_zero;
    logic [31:0] resp0_result, resp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 0; resp1_ready = 0;

        // Reset: quiet outputs even with a request pending.
        tick(); tick();
        req0_valid = 1; settle();
        check("rst_req0_ready", req0_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        req0_valid = 0; rst = 0;
        settle();
        check("post_rst_busy", busy, 0);

        // Single op: 5 + 7.
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = ALU_ADD; resp0_ready = 1;
        settle();
        check("single_req0_ready", req0_ready, 1);
        check("single_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0; settle();
        check("single_exec_busy", busy, 1);
        check("single_exec_ready", req0_ready, 0);
        check("single_exec_resp", resp0_valid, 0);
        check("single_alu_a", alu_a, 5);
        check("single_alu_b", alu_b, 7);
        check("single_alu_ctrl", alu_ctrl, ALU_ADD);
        tick();
        check("single_resp_valid", resp0_valid, 1);
        check("single_resp_result", resp0_result, 12);
        check("single_resp_zero", resp0_zero, 0);
        check("single_resp1_valid", resp1_valid, 0);
        tick();
        check("single_idle_busy", busy, 0);
        check("single_idle_resp", resp0_valid, 0);
        check("single_hold_alu_a", alu_a, 5);

        // Contention from a fresh reset: grants alternate 0,1,0,1.
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_a = 3;     req0_b = 3;     req0_op = ALU_SUB;
        req1_valid = 1; req1_a = 'hF0;  req1_b = 'h0F;  req1_op = ALU_XOR;
        resp0_ready = 1; resp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("cont%0d_req0_ready", k), req0_ready, (k % 2 == 0));
            check($sformatf("cont%0d_req1_ready", k), req1_ready, (k % 2 == 1));
            tick();
            check($sformatf("cont%0d_exec_busy", k), busy, 1);
            tick();
            if (k % 2 == 0) begin
                check($sformatf("cont%0d_resp0_valid", k), resp0_valid, 1);
                check($sformatf("cont%0d_resp1_valid", k), resp1_valid, 0);
                check($sformatf("cont%0d_resp0_result", k), resp0_result, 0);
                check($sformatf("cont%0d_resp0_zero", k), resp0_zero, 1);
            end else begin
                check($sformatf("cont%0d_resp1_valid", k), resp1_valid, 1);
                check($sformatf("cont%0d_resp0_valid", k), resp0_valid, 0);
                check($sformatf("cont%0d_resp1_result", k), resp1_result, 'hFF);
                check($sformatf("cont%0d_resp1_zero", k), resp1_zero, 0);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure on resp1: 10 + 20 held for 5 cycles while req0 waits.
        req1_valid = 1; req1_a = 10; req1_b = 20; req1_op = ALU_ADD; resp1_ready = 0;
        settle();
        check("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = ALU_ADD;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("bp%0d_resp1_valid", k), resp1_valid, 1);
            check($sformatf("bp%0d_resp1_result", k), resp1_result, 30);
            check($sformatf("bp%0d_resp1_zero", k), resp1_zero, 0);
            check($sformatf("bp%0d_req0_ready", k), req0_ready, 0);
            tick();
        end
        req0_valid = 0; resp1_ready = 1; settle();
        check("bp_release_valid", resp1_valid, 1);
        tick();
        check("bp_idle_busy", busy, 0);
        check("bp_idle_resp1", resp1_valid, 0);

        // Late arrival: req1 shows up while req0 (9 - 4) executes.
        req0_valid = 1; req0_a = 9; req0_b = 4; req0_op = ALU_SUB; resp0_ready = 1;
        settle();
        check("late_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_a = 2; req1_b = 3; req1_op = ALU_AND;
        settle();
        check("late_exec_req1_ready", req1_ready, 0);
        tick();
        check("late_resp_req1_ready", req1_ready, 0);
        check("late_resp0_valid", resp0_valid, 1);
        check("late_resp0_result", resp0_result, 5);
        tick();
        check("late_idle_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0; settle();
        check("late_exec_resp1", resp1_valid, 0);
        tick();
        check("late_resp1_valid", resp1_valid, 1);
        check("late_resp1_result", resp1_result, 2);
        check("late_resp1_zero", resp1_zero, 0);
        tick();

        // Withdraw: req0 pulses one cycle during req1's RESP (1 | 2).
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = ALU_OR; resp1_ready = 0;
        settle();
        check("wd_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        req0_valid = 1; req0_a = 77; req0_b = 0; req0_op = ALU_ADD; settle();
        check("wd_req0_ready", req0_ready, 0);
        check("wd_resp1_result", resp1_result, 3);
        tick();
        req0_valid = 0; resp1_ready = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wd%0d_idle_busy", k), busy, 0);
            check($sformatf("wd%0d_alu_a", k), alu_a, 1);
            tick();
        end

        // Mid-op reset during SLT: operation dropped, prio back to 0.
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = ALU_SLT; resp0_ready = 1;
        settle();
        check("mr_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0; rst = 1; settle();
        check("mr_during_busy", busy, 0);
        tick();
        rst = 0; settle();
        check("mr_busy", busy, 0);
        check("mr_resp0_valid", resp0_valid, 0);
        check("mr_alu_a", alu_a, 0);
        check("mr_alu_b", alu_b, 0);
        check("mr_alu_ctrl", alu_ctrl, 0);
        check("mr_resp0_result", resp0_result, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mr%0d_no_resp0", k), resp0_valid, 0);
        end
        req0_valid = 1; req1_valid = 1; settle();
        check("mr_prio_req0_ready", req0_ready, 1);
        check("mr_prio_req1_ready", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
